// File: rtl/spi_reg_device.sv
// SPI register pseudo-device: NUM_REGS registers served by framed R/W transactions
// (R/W bit, address, data; MSB first) on a clk-synchronous cs/mosi/miso link.
module spi_reg_device #(
   parameter int                NUM_REGS  = 4,
   parameter int                DATA_W    = 8,
   parameter int                ADDR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
   parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(8'hAD)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cs,
   input  logic                       mosi,
   output logic                       miso,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       frame_abort,
   output logic                       addr_err,
   output logic [NUM_REGS*DATA_W-1:0] regs_o
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   localparam int MAX_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
   localparam int CNT_W = $clog2(MAX_W) + 1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_rw;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_shift;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_regs [NUM_REGS];

   logic [ADDR_W-1:0]   w_addr_full;
   logic [DATA_W-1:0]   w_data_full;
   logic                w_addr_ok;
   logic                w_cur_ok;
   logic                w_addr_last;
   logic                w_data_last;
   logic [DATA_W-1:0]   w_rd_data;
   logic                w_commit;
   logic                w_done_nxt;
   logic                w_abort_nxt;
   logic                w_aerr_nxt;

   // Width casts drop the oldest bit, so this also works for ADDR_W == 1.
   assign w_addr_full = ADDR_W'({r_addr, mosi});
   assign w_data_full = DATA_W'({r_shift, mosi});
   assign w_addr_ok   = ({1'b0, w_addr_full} < (ADDR_W + 1)'(NUM_REGS));
   assign w_cur_ok    = ({1'b0, r_addr} < (ADDR_W + 1)'(NUM_REGS));
   assign w_addr_last = (r_cnt == CNT_W'(ADDR_W - 1));
   assign w_data_last = (r_cnt == CNT_W'(DATA_W - 1));

   always_comb begin
      w_rd_data = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (w_addr_full == ADDR_W'(i)) w_rd_data = r_regs[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      w_abort_nxt = 1'b0;
      w_aerr_nxt  = 1'b0;
      w_commit    = 1'b0;
      if (cs) begin
         w_state_nxt = IDLE;
         w_abort_nxt = (r_state == ADDR) || (r_state == DATA);
      end else begin
         case (r_state)
            IDLE: w_state_nxt = ADDR;
            ADDR: begin
               if (w_addr_last) begin
                  w_state_nxt = DATA;
                  w_aerr_nxt  = !w_addr_ok;
               end
            end
            DATA: begin
               if (w_data_last) begin
                  w_state_nxt = DONE;
                  w_done_nxt  = 1'b1;
                  w_commit    = !r_rw && w_cur_ok;
               end
            end
            default: w_state_nxt = DONE;
         endcase
      end
   end

   assign busy = (r_state == ADDR) || (r_state == DATA) || ((r_state == IDLE) && !cs);
   assign miso = (r_state == DATA) && r_rw && r_shift[DATA_W-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_done  <= 1'b0;
         frame_abort <= 1'b0;
         addr_err    <= 1'b0;
         r_rw        <= 1'b0;
         r_addr      <= '0;
         r_shift     <= '0;
         r_cnt       <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
      end else begin
         frame_done  <= w_done_nxt;
         frame_abort <= w_abort_nxt;
         addr_err    <= w_aerr_nxt;
         if (!cs) begin
            case (r_state)
               IDLE: begin
                  r_rw   <= mosi;
                  r_addr <= '0;
                  r_cnt  <= '0;
               end
               ADDR: begin
                  r_addr <= w_addr_full;
                  if (w_addr_last) begin
                     r_cnt   <= '0;
                     r_shift <= (r_rw && w_addr_ok) ? w_rd_data : '0;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               DATA: begin
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_shift <= r_rw ? (r_shift << 1) : w_data_full;
                  for (int unsigned i = 0; i < NUM_REGS; i++) begin
                     if (w_commit && (r_addr == ADDR_W'(i))) r_regs[i] <= w_data_full;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
      assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
   end

endmodule

// File: tb/tb_spi_reg_device.sv
// Directed bench for spi_reg_device: a 4-register and a 3-register instance share
// the same clock, reset and SPI stimulus; outputs are checked with immediate asserts.
module tb_spi_reg_device;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs = 1'b1;
   logic        mosi = 1'b0;

   logic        miso, busy, done, abort, aerr;
   logic [31:0] regs;
   logic        miso3, busy3, done3, abort3, aerr3;
   logic [23:0] regs3;

   int checks = 0;
   int errors = 0;

   logic [7:0] q4, q3;

   always #5 clk = ~clk;

   spi_reg_device #(.NUM_REGS(4)) dut (
      .clk(clk), .rst(rst), .cs(cs), .mosi(mosi),
      .miso(miso), .busy(busy), .frame_done(done), .frame_abort(abort),
      .addr_err(aerr), .regs_o(regs)
   );

   spi_reg_device #(.NUM_REGS(3)) dut3 (
      .clk(clk), .rst(rst), .cs(cs), .mosi(mosi),
      .miso(miso3), .busy(busy3), .frame_done(done3), .frame_abort(abort3),
      .addr_err(aerr3), .regs_o(regs3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply inputs, take one rising edge, then settle 1 time unit before sampling.
   task automatic clk_edge(input logic c, input logic m);
      cs   = c;
      mosi = m;
      @(posedge clk);
      #1;
   endtask

   task automatic send_hdr(input logic rw, input logic [1:0] a);
      clk_edge(1'b0, rw);
      clk_edge(1'b0, a[1]);
      clk_edge(1'b0, a[0]);
   endtask

   task automatic rd_data(output logic [7:0] d4, output logic [7:0] d3);
      for (int i = 7; i >= 0; i--) begin
         d4[i] = miso;
         d3[i] = miso3;
         clk_edge(1'b0, 1'b0);
      end
   endtask

   task automatic wr_data(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) clk_edge(1'b0, d[i]);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset
      rst = 1'b1;
      clk_edge(1'b1, 1'b0);
      clk_edge(1'b1, 1'b0);
      check("rst_regs",  regs, 32'hADADADAD);
      check("rst_regs3", {8'h0, regs3}, 32'h00ADADAD);
      check("rst_outs",  {27'h0, miso, busy, done, abort, aerr}, 32'h0);
      rst = 1'b0;
      clk_edge(1'b1, 1'b0);

      // Read reg 0
      send_hdr(1'b1, 2'd0);
      check("rd0_busy", {31'h0, busy}, 32'h1);
      for (int i = 7; i >= 1; i--) begin
         q4[i] = miso;
         clk_edge(1'b0, 1'b0);
      end
      q4[0] = miso;
      check("rd0_done_early", {31'h0, done}, 32'h0);
      clk_edge(1'b0, 1'b0);
      check("rd0_data", {24'h0, q4}, 32'h000000AD);
      check("rd0_done", {31'h0, done}, 32'h1);
      check("rd0_miso_done", {31'h0, miso}, 32'h0);
      clk_edge(1'b1, 1'b0);
      check("rd0_idle", {29'h0, busy, done, abort}, 32'h0);

      // Write 3C to reg 2, read it back
      send_hdr(1'b0, 2'd2);
      wr_data(8'h3C);
      check("wr2_done", {31'h0, done}, 32'h1);
      check("wr2_reg", {24'h0, regs[23:16]}, 32'h0000003C);
      clk_edge(1'b1, 1'b0);
      send_hdr(1'b1, 2'd2);
      rd_data(q4, q3);
      check("rd2_data", {24'h0, q4}, 32'h0000003C);
      check("rd2_regs", regs, 32'hAD3CADAD);
      clk_edge(1'b1, 1'b0);

      // Abort a write to reg 1 after 5 data bits
      send_hdr(1'b0, 2'd1);
      clk_edge(1'b0, 1'b0);
      clk_edge(1'b0, 1'b0);
      clk_edge(1'b0, 1'b0);
      clk_edge(1'b0, 1'b1);
      clk_edge(1'b0, 1'b0);
      check("ab_busy", {31'h0, busy}, 32'h1);
      clk_edge(1'b1, 1'b0);
      check("ab_pulse", {30'h0, abort, done}, 32'h2);
      clk_edge(1'b1, 1'b0);
      check("ab_once", {30'h0, abort, done}, 32'h0);
      check("ab_regs", regs, 32'hAD3CADAD);
      send_hdr(1'b1, 2'd2);
      rd_data(q4, q3);
      check("ab_next_rd", {24'h0, q4}, 32'h0000003C);
      clk_edge(1'b1, 1'b0);

      // Write 5A to reg 0, then 4 extra edges with cs low
      send_hdr(1'b0, 2'd0);
      wr_data(8'h5A);
      check("ex_done", {31'h0, done}, 32'h1);
      for (int i = 0; i < 4; i++) begin
         clk_edge(1'b0, i[0] ? 1'b0 : 1'b1);
         check("ex_quiet", {29'h0, miso, done, busy}, 32'h0);
      end
      check("ex_regs", regs, 32'hAD3CAD5A);
      clk_edge(1'b1, 1'b0);

      // Address 3: out of range only for the 3-register instance
      send_hdr(1'b1, 2'd3);
      check("oor_rd_aerr", {30'h0, aerr3, aerr}, 32'h2);
      rd_data(q4, q3);
      check("oor_rd_miso3", {24'h0, q3}, 32'h0);
      check("oor_rd_miso4", {24'h0, q4}, 32'h000000AD);
      check("oor_rd_aerr_end", {30'h0, aerr3, aerr}, 32'h0);
      clk_edge(1'b1, 1'b0);
      send_hdr(1'b0, 2'd3);
      check("oor_wr_aerr", {31'h0, aerr3}, 32'h1);
      wr_data(8'hFF);
      check("oor_wr_done3", {31'h0, done3}, 32'h1);
      check("oor_wr_regs3", {8'h0, regs3}, 32'h003CAD5A);
      check("oor_wr_regs4", regs, 32'hFF3CAD5A);
      clk_edge(1'b1, 1'b0);

      // Reset in the middle of a write of 00 to reg 0
      send_hdr(1'b0, 2'd0);
      clk_edge(1'b0, 1'b0);
      clk_edge(1'b0, 1'b0);
      clk_edge(1'b0, 1'b0);
      rst = 1'b1;
      clk_edge(1'b1, 1'b0);
      check("mr_regs", regs, 32'hADADADAD);
      check("mr_outs", {27'h0, miso, busy, done, abort, aerr}, 32'h0);
      rst = 1'b0;
      clk_edge(1'b1, 1'b0);
      check("mr_no_abort", {31'h0, abort}, 32'h0);
      send_hdr(1'b1, 2'd3);
      rd_data(q4, q3);
      check("mr_rd3", {24'h0, q4}, 32'h000000AD);
      check("mr_rd_done", {31'h0, done}, 32'h1);
      clk_edge(1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
